// File: rtl/lm32_dtlb_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lm32_dtlb_walker_pkg
// Description : Shared definitions for the LM32 DTLB page-table walker.
//               These include the walker state encoding, the DTLB CSR indices,
//               the PTE valid-bit position, the TLB operation codes and a
//               helper that formats DTLB CSR write data.
// Revision    : 1.0 - initial release
// ============================================================================
package lm32_dtlb_walker_pkg;

  // Walker state encoding
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_IDLE     = 3'd0;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_L1       = 3'd1;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_L2       = 3'd2;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_WR_V     = 3'd3;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_WR_P     = 3'd4;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_DONE     = 3'd5;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_FAULT    = 3'd6;
  localparam logic [2:0] LM32_DTLB_WALKER_STATE_WAIT_CLR = 3'd7;

  // DTLB CSR indices
  localparam logic [4:0] LM32_CSR_TLB_VADDRESS = 5'h11;
  localparam logic [4:0] LM32_CSR_TLB_PADDRESS = 5'h12;

  // Valid-bit position in a PTE (same position at both levels)
  localparam int LM32_PTE_VALID_BIT = 0;

  // TLB operation codes carried in bits 5:1 of a VADDRESS write
  typedef enum logic [4:0] {
    LM32_TLB_OP_NOOP       = 5'd0,
    LM32_TLB_OP_FLUSH      = 5'd1,
    LM32_TLB_OP_INVALIDATE = 5'd2
  } lm32_tlb_op_e;

  // Formats a DTLB CSR word: address bits 31:6, op in 5:1, bit 0 set.
  function automatic logic [31:0] tlb_csr_word(input logic [25:0] hi,
                                               input lm32_tlb_op_e op);
    return {hi, op, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lm32_dtlb_walker_if.sv
`default_nettype none
// ============================================================================
// Module      : lm32_dtlb_walker_if
// Description : Read-only Wishbone data-bus bundle used by the DTLB walker.
//               master : walker side (drives adr/cyc/stb/sel/we)
//               slave  : memory side (drives dat_i/ack/err)
// Revision    : 1.0 - initial release
// ============================================================================
interface lm32_dtlb_walker_if;
  logic [31:0] d_adr_o;
  logic        d_cyc_o;
  logic        d_stb_o;
  logic [3:0]  d_sel_o;
  logic        d_we_o;
  logic [31:0] d_dat_i;
  logic        d_ack_i;
  logic        d_err_i;

  modport master (
    output d_adr_o, d_cyc_o, d_stb_o, d_sel_o, d_we_o,
    input  d_dat_i, d_ack_i, d_err_i
  );

  modport slave (
    input  d_adr_o, d_cyc_o, d_stb_o, d_sel_o, d_we_o,
    output d_dat_i, d_ack_i, d_err_i
  );
endinterface
`default_nettype wire

// File: rtl/lm32_dtlb_walker.sv
`default_nettype none
// ============================================================================
// Module      : lm32_dtlb_walker
// Description : Hardware page-table walker that refills the LM32 data TLB.
//               On a DTLB miss it reads the two-level page table over a
//               read-only Wishbone master. It then writes TLB_VADDRESS
//               followed by TLB_PADDRESS, and it stalls the core (busy)
//               while the walk is in progress.
// Ports       : clk_i, rst_i           - clock, synchronous active-high reset
//               enable, ptbr           - walker enable, L1 table base
//               miss, miss_address     - DTLB miss and faulting VA
//               busy, done, fault      - status (done/fault are 1-cycle pulses)
//               fault_address          - VA of the most recent fault
//               wb (master modport)    - Wishbone data bus
//               csr, csr_write_data,
//               csr_write_enable       - DTLB CSR write port
// Config      : `define CFG_DTLB_WALKER_TIMEOUT_EN to enable the bus watchdog
//               (TIMEOUT_CYCLES); without it the walker waits indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module lm32_dtlb_walker
  import lm32_dtlb_walker_pkg::*;
#(
  parameter int PAGE_SIZE      = 4096,
  parameter int L1_INDEX_WIDTH = 10
`ifdef CFG_DTLB_WALKER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  input  wire logic          enable,
  input  wire logic [31:0]   ptbr,
  input  wire logic          miss,
  input  wire logic [31:0]   miss_address,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [31:0]        fault_address,
  lm32_dtlb_walker_if.master wb,
  output logic [4:0]         csr,
  output logic [31:0]        csr_write_data,
  output logic               csr_write_enable
);

  localparam int c_OFFSET_W = $clog2(PAGE_SIZE);
  localparam int c_L2_W     = 32 - L1_INDEX_WIDTH - c_OFFSET_W;

  logic [2:0]              r_state;
  logic [31:0]             r_va;
  logic [31:c_OFFSET_W]    r_l2_base;
  logic [31:c_OFFSET_W]    r_pfn;
  logic [31:0]             r_fault_address;
  logic                    r_cyc;
  logic [31:0]             r_adr;

  logic [31:0]             w_l1_adr;
  logic [31:0]             w_l2_adr;
  logic [31:0]             w_req_adr;
  logic                    w_pte_valid;
  logic                    w_unused_pte_bits;

`ifdef CFG_DTLB_WALKER_TIMEOUT_EN
  localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [c_CNT_W-1:0]      r_cnt;
`endif

  // Both table levels share one request datapath. The entry address is the
  // table base plus the VA index scaled to words, and the sum wraps at 32 bits.
  assign w_l1_adr  = ptbr + {{(32-L1_INDEX_WIDTH-2){1'b0}}, r_va[31 -: L1_INDEX_WIDTH], 2'b00};
  assign w_l2_adr  = {r_l2_base, {c_OFFSET_W{1'b0}}}
                   + {{(32-c_L2_W-2){1'b0}}, r_va[c_OFFSET_W +: c_L2_W], 2'b00};
  assign w_req_adr = (r_state == LM32_DTLB_WALKER_STATE_L1) ? w_l1_adr : w_l2_adr;

  assign w_pte_valid       = wb.d_dat_i[LM32_PTE_VALID_BIT];
  assign w_unused_pte_bits = ^wb.d_dat_i[c_OFFSET_W-1:1];

  assign wb.d_adr_o     = r_adr;
  assign wb.d_cyc_o     = r_cyc;
  assign wb.d_stb_o     = r_cyc;
  assign wb.d_sel_o     = 4'hF;
  assign wb.d_we_o      = 1'b0;
  assign fault_address  = r_fault_address;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= LM32_DTLB_WALKER_STATE_IDLE;
      r_va            <= '0;
      r_l2_base       <= '0;
      r_pfn           <= '0;
      r_fault_address <= '0;
      r_cyc           <= 1'b0;
      r_adr           <= '0;
`ifdef CFG_DTLB_WALKER_TIMEOUT_EN
      r_cnt           <= '0;
`endif
    end else begin
      case (r_state)
        LM32_DTLB_WALKER_STATE_IDLE: begin
          if (enable && miss) begin
            r_va    <= miss_address;
            r_state <= LM32_DTLB_WALKER_STATE_L1;
          end
        end

        // Each level spends its first cycle with cyc low and then issues the
        // request. This guarantees the idle cycle between the L1 and L2 reads.
        LM32_DTLB_WALKER_STATE_L1,
        LM32_DTLB_WALKER_STATE_L2: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_adr <= w_req_adr;
`ifdef CFG_DTLB_WALKER_TIMEOUT_EN
            r_cnt <= '0;
`endif
          end else if (wb.d_err_i || (wb.d_ack_i && !w_pte_valid)) begin
            // err takes priority over a simultaneous ack
            r_cyc           <= 1'b0;
            r_fault_address <= r_va;
            r_state         <= LM32_DTLB_WALKER_STATE_FAULT;
          end else if (wb.d_ack_i) begin
            r_cyc <= 1'b0;
            if (r_state == LM32_DTLB_WALKER_STATE_L1) begin
              r_l2_base <= wb.d_dat_i[31:c_OFFSET_W];
              r_state   <= LM32_DTLB_WALKER_STATE_L2;
            end else begin
              r_pfn     <= wb.d_dat_i[31:c_OFFSET_W];
              r_state   <= LM32_DTLB_WALKER_STATE_WR_V;
            end
          end
`ifdef CFG_DTLB_WALKER_TIMEOUT_EN
          else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cyc           <= 1'b0;
            r_fault_address <= r_va;
            r_state         <= LM32_DTLB_WALKER_STATE_FAULT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        LM32_DTLB_WALKER_STATE_WR_V:  r_state <= LM32_DTLB_WALKER_STATE_WR_P;
        LM32_DTLB_WALKER_STATE_WR_P:  r_state <= LM32_DTLB_WALKER_STATE_DONE;
        LM32_DTLB_WALKER_STATE_DONE:  r_state <= LM32_DTLB_WALKER_STATE_WAIT_CLR;
        LM32_DTLB_WALKER_STATE_FAULT: r_state <= LM32_DTLB_WALKER_STATE_WAIT_CLR;

        // The DTLB miss is sticky. Wait for it to clear so that the walker
        // does not refill the same page twice.
        LM32_DTLB_WALKER_STATE_WAIT_CLR: begin
          if (!miss) r_state <= LM32_DTLB_WALKER_STATE_IDLE;
        end

        default: r_state <= LM32_DTLB_WALKER_STATE_IDLE;
      endcase
    end
  end

  // VADDRESS must precede PADDRESS, because the PADDRESS write commits the
  // entry using the virtual address latched by the previous write.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    fault            = 1'b0;
    csr              = 5'd0;
    csr_write_data   = 32'd0;
    csr_write_enable = 1'b0;
    case (r_state)
      LM32_DTLB_WALKER_STATE_L1,
      LM32_DTLB_WALKER_STATE_L2: busy = 1'b1;
      LM32_DTLB_WALKER_STATE_WR_V: begin
        busy             = 1'b1;
        csr              = LM32_CSR_TLB_VADDRESS;
        csr_write_enable = 1'b1;
        csr_write_data   = tlb_csr_word({r_va[31:c_OFFSET_W], {(c_OFFSET_W-6){1'b0}}},
                                        LM32_TLB_OP_NOOP);
      end
      LM32_DTLB_WALKER_STATE_WR_P: begin
        busy             = 1'b1;
        csr              = LM32_CSR_TLB_PADDRESS;
        csr_write_enable = 1'b1;
        csr_write_data   = tlb_csr_word({r_pfn, {(c_OFFSET_W-6){1'b0}}},
                                        LM32_TLB_OP_NOOP);
      end
      LM32_DTLB_WALKER_STATE_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      LM32_DTLB_WALKER_STATE_FAULT: begin
        busy  = 1'b1;
        fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lm32_dtlb_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm32_dtlb_walker
// Description : Directed self-checking bench for lm32_dtlb_walker. It covers
//               reset values, the enable gate, a full walk, an invalid L1 PTE,
//               an L2 bus error, ack+err priority, the sticky-miss hold-off
//               and reset in the middle of a walk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm32_dtlb_walker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable;
  logic [31:0] ptbr;
  logic        miss;
  logic [31:0] miss_address;
  logic        busy, done, fault;
  logic [31:0] fault_address;
  logic [4:0]  csr;
  logic [31:0] csr_write_data;
  logic        csr_write_enable;

  int checks = 0;
  int errors = 0;
  int csr_writes = 0;

  lm32_dtlb_walker_if wb ();

  lm32_dtlb_walker dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable           (enable),
    .ptbr             (ptbr),
    .miss             (miss),
    .miss_address     (miss_address),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .fault_address    (fault_address),
    .wb               (wb.master),
    .csr              (csr),
    .csr_write_data   (csr_write_data),
    .csr_write_enable (csr_write_enable)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (csr_write_enable) csr_writes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a bus request, checks its address, then answers it
  // for exactly one clock. Returns at posedge+1 after the response edge.
  task automatic bus_read(input string tag, input logic [31:0] exp_adr,
                          input logic [31:0] dat, input logic ack, input logic err);
    int n = 0;
    @(negedge clk_i);
    while (!wb.d_cyc_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_cyc"}, {31'd0, wb.d_cyc_o}, 32'd1);
    check({tag, "_stb"}, {31'd0, wb.d_stb_o}, 32'd1);
    check({tag, "_adr"}, wb.d_adr_o, exp_adr);
    wb.d_dat_i = dat;
    wb.d_ack_i = ack;
    wb.d_err_i = err;
    @(posedge clk_i);
    #1;
    wb.d_dat_i = 32'd0;
    wb.d_ack_i = 1'b0;
    wb.d_err_i = 1'b0;
  endtask

  // Drops miss for one cycle, then raises it with a new faulting VA.
  task automatic rearm(input logic [31:0] va);
    @(posedge clk_i); #1 miss = 1'b0;
    @(posedge clk_i); #1 miss = 1'b1; miss_address = va;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation watchdog");
  end

  initial begin
    rst_i = 1'b1; enable = 1'b0; ptbr = 32'h0010_0000;
    miss = 1'b0; miss_address = 32'd0;
    wb.d_dat_i = 32'd0; wb.d_ack_i = 1'b0; wb.d_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset values
    @(negedge clk_i);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_faddr", fault_address,  32'd0);
    check("rst_cyc",   {31'd0, wb.d_cyc_o}, 32'd0);
    check("rst_csrwe", {31'd0, csr_write_enable}, 32'd0);
    check("rst_csrd",  csr_write_data, 32'd0);
    check("rst_sel",   {28'd0, wb.d_sel_o}, 32'hF);
    check("rst_we",    {31'd0, wb.d_we_o}, 32'd0);

    // With enable low, a miss is ignored
    @(posedge clk_i); #1 miss = 1'b1; miss_address = 32'h4020_3ABC;
    repeat (3) @(negedge clk_i);
    check("dis_busy", {31'd0, busy}, 32'd0);
    check("dis_cyc",  {31'd0, wb.d_cyc_o}, 32'd0);

    // Basic walk
    @(posedge clk_i); #1 enable = 1'b1;
    bus_read("walk_l1", 32'h0010_0400, 32'h0020_0001, 1'b1, 1'b0);
    #1 enable = 1'b0;   // dropping enable mid-walk must not abort it
    @(negedge clk_i);
    check("walk_gap_cyc", {31'd0, wb.d_cyc_o}, 32'd0);
    check("walk_busy",    {31'd0, busy}, 32'd1);
    bus_read("walk_l2", 32'h0020_080C, 32'h0ABC_D001, 1'b1, 1'b0);
    @(negedge clk_i);
    check("wrv_we",   {31'd0, csr_write_enable}, 32'd1);
    check("wrv_csr",  {27'd0, csr}, 32'h11);
    check("wrv_data", csr_write_data, 32'h4020_3001);
    @(negedge clk_i);
    check("wrp_we",   {31'd0, csr_write_enable}, 32'd1);
    check("wrp_csr",  {27'd0, csr}, 32'h12);
    check("wrp_data", csr_write_data, 32'h0ABC_D001);
    @(negedge clk_i);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_busy",  {31'd0, busy}, 32'd1);
    check("done_we",    {31'd0, csr_write_enable}, 32'd0);
    @(negedge clk_i);
    check("post_done",  {31'd0, done}, 32'd0);
    check("post_busy",  {31'd0, busy}, 32'd0);

    // Sticky miss: no second walk while miss stays high
    enable = 1'b1;
    repeat (4) @(negedge clk_i);
    check("sticky_busy", {31'd0, busy}, 32'd0);
    check("sticky_cyc",  {31'd0, wb.d_cyc_o}, 32'd0);
    check("walk_csr_writes", csr_writes, 32'd2);

    // Invalid L1 PTE
    rearm(32'h4020_3ABC);
    bus_read("inv_l1", 32'h0010_0400, 32'h0020_0000, 1'b1, 1'b0);
    @(negedge clk_i);
    check("inv_fault", {31'd0, fault}, 32'd1);
    check("inv_faddr", fault_address, 32'h4020_3ABC);
    check("inv_we",    {31'd0, csr_write_enable}, 32'd0);
    @(negedge clk_i);
    check("inv_fault_off", {31'd0, fault}, 32'd0);
    check("inv_no_l2",     {31'd0, wb.d_cyc_o}, 32'd0);
    check("inv_busy",      {31'd0, busy}, 32'd0);

    // Bus error on the L2 read
    rearm(32'h8000_5123);
    bus_read("err_l1", 32'h0010_0800, 32'h0030_0001, 1'b1, 1'b0);
    bus_read("err_l2", 32'h0030_0014, 32'h0000_0001, 1'b0, 1'b1);
    @(negedge clk_i);
    check("err_fault", {31'd0, fault}, 32'd1);
    check("err_faddr", fault_address, 32'h8000_5123);

    // ack and err together on L1: err wins
    rearm(32'h0000_1000);
    bus_read("ae_l1", 32'h0010_0000, 32'h0040_0001, 1'b1, 1'b1);
    @(negedge clk_i);
    check("ae_fault", {31'd0, fault}, 32'd1);
    check("ae_faddr", fault_address, 32'h0000_1000);
    @(negedge clk_i);
    check("ae_no_l2", {31'd0, wb.d_cyc_o}, 32'd0);
    check("fault_csr_writes", csr_writes, 32'd2);

    // Reset during the L2 read
    rearm(32'h4020_3ABC);
    bus_read("rst_l1", 32'h0010_0400, 32'h0020_0001, 1'b1, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_l2_cyc", {31'd0, wb.d_cyc_o}, 32'd1);
    rst_i = 1'b1;
    miss  = 1'b0;
    @(negedge clk_i);
    check("rstw_cyc",   {31'd0, wb.d_cyc_o}, 32'd0);
    check("rstw_stb",   {31'd0, wb.d_stb_o}, 32'd0);
    check("rstw_busy",  {31'd0, busy}, 32'd0);
    check("rstw_faddr", fault_address, 32'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rstw_idle",  {31'd0, busy}, 32'd0);
    check("rstw_csr_writes", csr_writes, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
